// File: rtl/cache_dados_assoc.sv
// rtl/cache_dados_assoc.sv - N-way set-associative write-back, write-allocate data cache with miss FSM
//
// Purpose: MEM-stage data cache. Hits complete combinationally in IDLE; misses stall
// the pipeline while a WRITEBACK/REFILL FSM exchanges whole blocks with data_memory.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   address              byte address of the request
//   write_data           store data
//   mem_read, mem_write  load / store request (both high = store)
//   read_data            load data on a hit (0 otherwise)
//   stall                freeze pipeline (combinational)
//   mem_address          block-aligned address to data_memory
//   mem_write_data       victim block during writeback
//   mem_write_out        block write request
//   mem_read_out         block read request
//   mem_block_read_data  refill block, word i at bits [64i+63:64i]
//   mem_ready            memory completes the current request this cycle
//   hit_count            hits since reset
//   miss_count           misses since reset

module cache_dados_assoc #(
   parameter int WAYS  = 2,
   parameter int SETS  = 8,
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [63:0]           address,
   input  logic [63:0]           write_data,
   input  logic                  mem_read,
   input  logic                  mem_write,
   output logic [63:0]           read_data,
   output logic                  stall,
   output logic [63:0]           mem_address,
   output logic [64*WORDS-1:0]   mem_write_data,
   output logic                  mem_write_out,
   output logic                  mem_read_out,
   input  logic [64*WORDS-1:0]   mem_block_read_data,
   input  logic                  mem_ready,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);

   localparam int BW  = 64 * WORDS;
   localparam int WB  = $clog2(WORDS);
   localparam int SB  = $clog2(SETS);
   localparam int OFF = 3 + WB;
   localparam int TW  = 64 - OFF - SB;
   localparam int WIW = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL} state_t;

   state_t            state_q, state_d;

   logic              valid_q [WAYS][SETS];
   logic              dirty_q [WAYS][SETS];
   logic [TW-1:0]     tag_q   [WAYS][SETS];
   logic [BW-1:0]     data_q  [WAYS][SETS];
   logic              lru_q   [SETS];

   // Block address and victim way captured when the miss is detected.
   logic [63-OFF:0]   blk_q;
   logic [WIW-1:0]    victim_q;

   logic [31:0]       hit_count_q;
   logic [31:0]       miss_count_q;

   logic              req;
   logic [WB-1:0]     cur_word;
   logic [SB-1:0]     cur_set;
   logic [TW-1:0]     cur_tag;
   logic              hit;
   logic [WIW-1:0]    hit_way;
   logic [WIW-1:0]    victim;
   logic              victim_found;
   logic [SB-1:0]     l_set;
   logic [TW-1:0]     l_tag;
   logic              unused_ok;

   assign req       = mem_read | mem_write;
   assign cur_word  = address[OFF-1:3];
   assign cur_set   = address[OFF+SB-1:OFF];
   assign cur_tag   = address[63:OFF+SB];
   assign l_set     = blk_q[SB-1:0];
   assign l_tag     = blk_q[63-OFF:SB];
   assign unused_ok = ^address[2:0];

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][cur_set] && tag_q[w][cur_set] == cur_tag) begin
            hit     = 1'b1;
            hit_way = WIW'(w);
         end
      end
   end

   // Lowest-numbered invalid way wins; only a full set falls back to LRU.
   always_comb begin
      victim       = '0;
      victim_found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!victim_found && !valid_q[w][cur_set]) begin
            victim       = WIW'(w);
            victim_found = 1'b1;
         end
      end
      if (!victim_found && WAYS > 1) begin
         victim = WIW'(lru_q[cur_set]);
      end
   end

   always_comb begin
      state_d        = state_q;
      stall          = 1'b0;
      read_data      = '0;
      mem_read_out   = 1'b0;
      mem_write_out  = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (hit) begin
                  if (!mem_write) begin
                     read_data = data_q[hit_way][cur_set][{cur_word, 6'b0} +: 64];
                  end
               end else begin
                  stall = 1'b1;
                  if (valid_q[victim][cur_set] && dirty_q[victim][cur_set]) begin
                     state_d = S_WRITEBACK;
                  end else begin
                     state_d = S_REFILL;
                  end
               end
            end
         end
         S_WRITEBACK: begin
            stall = 1'b1;
            // Requests drop combinationally as soon as reset is asserted.
            if (!reset) begin
               mem_write_out  = 1'b1;
               mem_address    = {tag_q[victim_q][l_set], l_set, {OFF{1'b0}}};
               mem_write_data = data_q[victim_q][l_set];
            end
            if (mem_ready) begin
               state_d = S_REFILL;
            end
         end
         S_REFILL: begin
            stall = 1'b1;
            if (!reset) begin
               mem_read_out = 1'b1;
               mem_address  = {blk_q, {OFF{1'b0}}};
            end
            if (mem_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state: reset clears valid/dirty/LRU and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         hit_count_q  <= '0;
         miss_count_q <= '0;
         blk_q        <= '0;
         victim_q     <= '0;
         for (int s = 0; s < SETS; s++) begin
            lru_q[s] <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
               valid_q[w][s] <= 1'b0;
               dirty_q[w][s] <= 1'b0;
            end
         end
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && req) begin
            if (hit) begin
               hit_count_q    <= hit_count_q + 32'd1;
               lru_q[cur_set] <= ~hit_way[0];
               if (mem_write) begin
                  dirty_q[hit_way][cur_set] <= 1'b1;
               end
            end else begin
               miss_count_q <= miss_count_q + 32'd1;
               blk_q        <= address[63:OFF];
               victim_q     <= victim;
            end
         end
         if (state_q == S_REFILL && mem_ready) begin
            valid_q[victim_q][l_set] <= 1'b1;
            dirty_q[victim_q][l_set] <= 1'b0;
         end
      end
   end

   // Tag and data arrays survive reset; only the valid bits make them meaningful.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == S_IDLE && req && hit && mem_write) begin
            data_q[hit_way][cur_set][{cur_word, 6'b0} +: 64] <= write_data;
         end
         if (state_q == S_REFILL && mem_ready) begin
            data_q[victim_q][l_set] <= mem_block_read_data;
            tag_q[victim_q][l_set]  <= l_tag;
         end
      end
   end

endmodule
